// File: rtl/usb_tx_sequencer.sv
// USB transmit packet sequencer: steps SYNC, PID, FIFO payload, CRC16 and EOP through the byte datapath.
// Latency: control outputs decode from state in the same cycle; done pulses one cycle after the last EOP bit.
// Backpressure: the datapath paces bytes with load_byte; start is ignored while busy or during the done cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle packet request (pid, data_len, crc_en sampled with it)
//   pid               PID nibble, sent as {~pid,pid}
//   data_len          payload byte count, clamped to MAX_LEN
//   crc_en            append CRC low then CRC high byte
//   fifo_empty        TX FIFO empty flag (used only with UNDERRUN_CHECK_EN)
//   load_byte         datapath strobe: current byte finished, staged mux byte loaded
//   fsm_byte, select  staged byte and mux select (0=FIFO, 1=FSM, 2=CRC low, 3=CRC high)
//   load_en           force-load of the first (SYNC) byte
//   tim_rst, tim_en   bit timer control
//   idle, eop         encoder J / SE0 drive
//   eop_new_bit       bit strobe to the encoder during EOP
//   fifo_read         one-cycle FIFO pop
//   busy, done        packet in progress / one-cycle completion pulse
//   tx_err            sticky underrun flag, cleared by the next accepted start
//
// Optional feature macro: UNDERRUN_CHECK_EN (abort to EOP when the FIFO runs dry mid-payload).

module usb_tx_sequencer #(
  parameter int         BIT_CLKS  = 8,
  parameter int         MAX_LEN   = 64,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [6:0] data_len,
  input  logic       crc_en,
  input  logic       fifo_empty,
  input  logic       load_byte,
  output logic [7:0] fsm_byte,
  output logic [1:0] select,
  output logic       load_en,
  output logic       tim_rst,
  output logic       tim_en,
  output logic       idle,
  output logic       eop,
  output logic       eop_new_bit,
  output logic       fifo_read,
  output logic       busy,
  output logic       done,
  output logic       tx_err
);

  localparam int             CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [6:0]     LEN_CAP  = 7'(MAX_LEN);

  localparam logic [1:0] SEL_FIFO   = 2'd0;
  localparam logic [1:0] SEL_FSM    = 2'd1;
  localparam logic [1:0] SEL_CRC_LO = 2'd2;
  localparam logic [1:0] SEL_CRC_HI = 2'd3;

  // State names the byte currently on the wire; select/fsm_byte stage the next one.
  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [3:0]       pid_q;
  logic [6:0]       rem_q;
  logic             crc_q;
  logic             done_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             se0_half;  // first SE0 bit time already elapsed

  logic accept;
  logic in_eop;
  logic bit_tick;
  logic fifo_load;
  logic underrun;

  // The done cycle is already IDLE; masking start there keeps the pulse from overlapping a new packet.
  assign accept    = start && (state == S_IDLE) && !done_q;
  assign in_eop    = (state == S_EOP_SE0) || (state == S_EOP_J);
  assign bit_tick  = in_eop && (bit_cnt == CNT_LAST);
  assign fifo_load = load_byte && ((state == S_PID) || (state == S_DATA)) && (rem_q != 7'd0);

`ifdef UNDERRUN_CHECK_EN
  logic tx_err_q;

  assign underrun = fifo_load && fifo_empty;
  assign tx_err   = tx_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_err_q <= 1'b0;
    end else if (accept) begin
      tx_err_q <= 1'b0;
    end else if (underrun) begin
      tx_err_q <= 1'b1;
    end
  end
`else
  logic unused_fifo_empty;

  assign unused_fifo_empty = fifo_empty;
  assign underrun          = 1'b0;
  assign tx_err            = 1'b0;
`endif

  assign fifo_read   = fifo_load && !underrun;
  assign done        = done_q;
  assign eop_new_bit = bit_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pid_q    <= 4'd0;
      rem_q    <= 7'd0;
      crc_q    <= 1'b0;
      done_q   <= 1'b0;
      bit_cnt  <= '0;
      se0_half <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == S_EOP_J) && bit_tick;

      if (accept) begin
        pid_q <= pid;
        rem_q <= (data_len > LEN_CAP) ? LEN_CAP : data_len;
        crc_q <= crc_en;
      end else if (fifo_read) begin
        rem_q <= rem_q - 7'd1;
      end

      // Free-running bit timer, held at zero outside EOP so each EOP starts a full bit time.
      if (!in_eop || bit_tick) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (state != S_EOP_SE0) begin
        se0_half <= 1'b0;
      end else if (bit_tick) begin
        se0_half <= ~se0_half;
      end
    end
  end

  always_comb begin
    state_nx = state;
    fsm_byte = SYNC_BYTE;
    select   = SEL_FSM;
    load_en  = 1'b0;
    tim_rst  = 1'b0;
    tim_en   = 1'b0;
    idle     = 1'b0;
    eop      = 1'b0;
    busy     = 1'b1;

    case (state)
      S_IDLE: begin
        idle = 1'b1;
        busy = 1'b0;
        if (accept) begin
          state_nx = S_ARM;
        end
      end

      S_ARM: begin
        idle     = 1'b1;
        load_en  = 1'b1;
        tim_rst  = 1'b1;
        state_nx = S_SYNC;
      end

      S_SYNC: begin
        tim_en   = 1'b1;
        fsm_byte = {~pid_q, pid_q};
        if (load_byte) begin
          state_nx = S_PID;
        end
      end

      S_PID, S_DATA: begin
        tim_en = 1'b1;
        if (rem_q != 7'd0) begin
          select = SEL_FIFO;
        end else if (crc_q) begin
          select = SEL_CRC_LO;
        end
        if (load_byte) begin
          if (underrun) begin
            state_nx = S_EOP_SE0;
          end else if (rem_q != 7'd0) begin
            state_nx = S_DATA;
          end else if (crc_q) begin
            state_nx = S_CRC_LO;
          end else begin
            state_nx = S_EOP_SE0;
          end
        end
      end

      S_CRC_LO: begin
        tim_en = 1'b1;
        select = SEL_CRC_HI;
        if (load_byte) begin
          state_nx = S_CRC_HI;
        end
      end

      S_CRC_HI: begin
        tim_en = 1'b1;
        if (load_byte) begin
          state_nx = S_EOP_SE0;
        end
      end

      S_EOP_SE0: begin
        eop = 1'b1;
        if (bit_tick && se0_half) begin
          state_nx = S_EOP_J;
        end
      end

      S_EOP_J: begin
        if (bit_tick) begin
          state_nx = S_IDLE;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
module tb_usb_tx_sequencer;

  localparam int BIT_CLKS = 8;
  localparam int MAX_LEN  = 64;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       start      = 1'b0;
  logic [3:0] pid        = 4'd0;
  logic [6:0] data_len   = 7'd0;
  logic       crc_en     = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       load_byte  = 1'b0;

  logic [7:0] fsm_byte;
  logic [1:0] select;
  logic       load_en, tim_rst, tim_en, idle, eop, eop_new_bit;
  logic       fifo_read, busy, done, tx_err;

  usb_tx_sequencer #(
    .BIT_CLKS (BIT_CLKS),
    .MAX_LEN  (MAX_LEN),
    .SYNC_BYTE(8'h80)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pid        (pid),
    .data_len   (data_len),
    .crc_en     (crc_en),
    .fifo_empty (fifo_empty),
    .load_byte  (load_byte),
    .fsm_byte   (fsm_byte),
    .select     (select),
    .load_en    (load_en),
    .tim_rst    (tim_rst),
    .tim_en     (tim_en),
    .idle       (idle),
    .eop        (eop),
    .eop_new_bit(eop_new_bit),
    .fifo_read  (fifo_read),
    .busy       (busy),
    .done       (done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Observations of one packet
  int obs_sel[$];
  int obs_byte[$];
  int reads, viol, eop_cnt, j_cnt, nbit_cnt, done_cnt;
  int gap = 2;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Datapath stand-in: load_byte strobes at random spacing, in every state.
  task automatic drive_load_byte();
    if (gap == 0) begin
      load_byte = 1'b1;
      gap       = $urandom_range(1, 4);
    end else begin
      load_byte = 1'b0;
      gap--;
    end
  endtask

  task automatic clear_obs();
    obs_sel.delete();
    obs_byte.delete();
    reads = 0; viol = 0; eop_cnt = 0; j_cnt = 0; nbit_cnt = 0; done_cnt = 0;
  endtask

  // Record what the encoder side would see this cycle (called at negedge).
  task automatic sample();
    if (load_en) begin
      obs_sel.push_back(int'(select));
      obs_byte.push_back(int'(fsm_byte));
    end
    if (load_byte && tim_en) begin
      obs_sel.push_back(int'(select));
      obs_byte.push_back(int'(fsm_byte));
    end
    if (fifo_read) begin
      reads++;
      if (!load_byte) viol++;
    end
    if (eop) eop_cnt++;
    if (busy && !idle && !tim_en && !eop) j_cnt++;
    if (eop_new_bit) nbit_cnt++;
    if (done) done_cnt++;
  endtask

  // One packet end to end. uk>0 requests a FIFO underrun at the uk-th payload load.
  // exp_reads_tab / exp_bytes_tab < 0 skip the hand-written table expectations.
  task automatic run_packet(input logic [3:0] p, input int len, input bit c, input int uk,
                            input bit poke_busy, input bit poke_done,
                            input int exp_reads_tab, input int exp_bytes_tab, input string tag);
    int  n, nbytes, exp_rec, nchk, exp_reads, cyc, after;
    bit  err, fin, third;
    int  esel[$];
    int  ebyte[$];

    // Reference: the list of bytes loaded into the shift register, in order.
    n = (len > MAX_LEN) ? MAX_LEN : len;
    esel.push_back(1); ebyte.push_back(8'h80);
    esel.push_back(1); ebyte.push_back((15 - int'(p)) * 16 + int'(p));
    if (uk > 0 && uk <= n) begin
      for (int i = 0; i < uk; i++) begin esel.push_back(0); ebyte.push_back(-1); end
      exp_reads = uk - 1;
      err       = 1'b1;
      exp_rec   = 2 + uk;
      nchk      = exp_rec;
      nbytes    = 2 + uk - 1;
    end else begin
      for (int i = 0; i < n; i++) begin esel.push_back(0); ebyte.push_back(-1); end
      if (c) begin
        esel.push_back(2); ebyte.push_back(-1);
        esel.push_back(3); ebyte.push_back(-1);
      end
      exp_reads = n;
      err       = 1'b0;
      nbytes    = 2 + n + (c ? 2 : 0);
      exp_rec   = nbytes + 1;  // the final load_byte ends the packet and is also seen
      nchk      = nbytes;
    end

    clear_obs();
    @(posedge clk); #1;
    pid = p; data_len = 7'(len); crc_en = c; start = 1'b1; fifo_empty = 1'b0;
    cyc = 0; after = -1; fin = 1'b0; third = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      sample();
      third = eop_new_bit && (nbit_cnt == 3);
      if (after < 0) begin
        if (done) after = 0;
      end else begin
        after++;
        if (after >= 6) fin = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 0) begin
        // Inputs must have been latched; scramble them.
        pid = 4'($urandom); data_len = 7'($urandom); crc_en = 1'($urandom);
      end
      if (poke_busy && cyc == 20) start = 1'b1;
      if (poke_done && third) start = 1'b1;   // lands on the done cycle
      drive_load_byte();
`ifdef UNDERRUN_CHECK_EN
      fifo_empty = (uk > 0) && (reads >= uk - 1);
`else
      fifo_empty = 1'($urandom);
`endif
      cyc++;
    end
    start = 1'b0;

    check({tag, " finished"}, int'(fin), 1);
    check({tag, " load count"}, obs_sel.size(), exp_rec);
    for (int i = 0; i < nchk && i < obs_sel.size(); i++) begin
      check($sformatf("%s sel[%0d]", tag, i), obs_sel[i], esel[i]);
      if (ebyte[i] >= 0) check($sformatf("%s byte[%0d]", tag, i), obs_byte[i], ebyte[i]);
    end
    check({tag, " fifo_read count"}, reads, exp_reads);
    check({tag, " fifo_read off load_byte"}, viol, 0);
    check({tag, " eop clks"}, eop_cnt, 2 * BIT_CLKS);
    check({tag, " J clks"}, j_cnt, BIT_CLKS);
    check({tag, " eop_new_bit pulses"}, nbit_cnt, 3);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " busy after"}, int'(busy), 0);
    check({tag, " idle after"}, int'(idle), 1);
    check({tag, " tx_err"}, int'(tx_err), int'(err));
    if (exp_reads_tab >= 0) check({tag, " table reads"}, reads, exp_reads_tab);
    if (exp_bytes_tab >= 0) check({tag, " table bytes"}, obs_sel.size() - 1, exp_bytes_tab);

    if (!fin) begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] pid;
    int         len;
    bit         crc;
    int         exp_reads;
    int         exp_bytes;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int r;
    bit hit;

    vecs[0] = '{pid: 4'h2, len: 0,   crc: 1'b0, exp_reads: 0,  exp_bytes: 2};
    vecs[1] = '{pid: 4'h3, len: 3,   crc: 1'b1, exp_reads: 3,  exp_bytes: 7};
    vecs[2] = '{pid: 4'h5, len: 64,  crc: 1'b0, exp_reads: 64, exp_bytes: 66};
    vecs[3] = '{pid: 4'h9, len: 100, crc: 1'b1, exp_reads: 64, exp_bytes: 68};
    vecs[4] = '{pid: 4'hF, len: 0,   crc: 1'b1, exp_reads: 0,  exp_bytes: 4};
    vecs[5] = '{pid: 4'h1, len: 1,   crc: 1'b0, exp_reads: 1,  exp_bytes: 3};
    vecs[6] = '{pid: 4'hA, len: 65,  crc: 1'b0, exp_reads: 64, exp_bytes: 66};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst fsm_byte", int'(fsm_byte), 8'h80);
    check("rst select", int'(select), 1);
    check("rst load_en", int'(load_en), 0);
    check("rst tim_rst", int'(tim_rst), 0);
    check("rst tim_en", int'(tim_en), 0);
    check("rst idle", int'(idle), 1);
    check("rst eop", int'(eop), 0);
    check("rst eop_new_bit", int'(eop_new_bit), 0);
    check("rst fifo_read", int'(fifo_read), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst tx_err", int'(tx_err), 0);
    rst = 1'b0;

    // Table-driven packets
    foreach (vecs[i]) begin
      run_packet(vecs[i].pid, vecs[i].len, vecs[i].crc, 0, 1'b0, 1'b0,
                 vecs[i].exp_reads, vecs[i].exp_bytes, $sformatf("vec%0d", i));
    end

    // start while busy and start on the done cycle are both ignored
    run_packet(4'h3, 3, 1'b1, 0, 1'b1, 1'b0, 3, 7, "poke_busy");
    run_packet(4'h2, 0, 1'b0, 0, 1'b0, 1'b1, 0, 2, "poke_done");

    // Reset in the middle of the payload
    @(posedge clk); #1;
    pid = 4'h4; data_len = 7'd5; crc_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r = 0; hit = 1'b0;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(negedge clk);
      if (fifo_read) r++;
      if (r == 2) hit = 1'b1;
      else begin
        @(posedge clk); #1;
        drive_load_byte();
      end
    end
    check("midrst reached DATA", int'(hit), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst idle", int'(idle), 1);
    check("midrst tim_en", int'(tim_en), 0);
    check("midrst eop", int'(eop), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst fifo_read", int'(fifo_read), 0);
    load_byte = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_packet(4'h4, 5, 1'b1, 0, 1'b0, 1'b0, 5, 9, "after_rst");

`ifdef UNDERRUN_CHECK_EN
    run_packet(4'h6, 4, 1'b1, 3, 1'b0, 1'b0, 2, 4, "underrun");
    run_packet(4'h7, 2, 1'b0, 0, 1'b0, 1'b0, 2, 4, "post_underrun");
`endif

    // Randomized packets against the reference list
    for (int k = 0; k < 12; k++) begin
      logic [3:0] rp;
      int         rl;
      bit         rc;
      rp = 4'($urandom_range(0, 15));
      rl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 127)) : int'($urandom_range(0, 20));
      rc = 1'($urandom);
      run_packet(rp, rl, rc, 0, 1'($urandom), 1'($urandom), -1, -1, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
Packet-level controller for the transmit byte datapath: sequences SYNC, PID, FIFO payload, CRC16 and EOP through the datapath's byte mux, timer and encoder controls. Accepts one packet request at a time from the protocol FSM. Uses the datapath's byte-complete strobe to stage the next byte, and owns EOP bit timing.

Parameters:
BIT_CLKS, 8, clocks per USB bit time; period of eop_new_bit during EOP.
MAX_LEN, 64, maximum payload bytes per packet; larger data_len is clamped to this value.
SYNC_BYTE, 8'h80, SYNC pattern driven on fsm_byte.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle packet request; ignored while busy=1
pid  in  4  PID nibble; transmitted byte is {~pid,pid}
data_len  in  7  payload byte count, 0..MAX_LEN
crc_en  in  1  append CRC low byte then CRC high byte
fifo_empty  in  1  TX FIFO empty flag
load_byte  in  1  datapath strobe: current byte done, next byte loaded from mux
fsm_byte  out  8  byte presented to mux input FSM
select  out  2  mux select: 0=FIFO, 1=FSM, 2=CRC low, 3=CRC high
load_en  out  1  force-load of the mux byte into the shift register
tim_rst  out  1  timer sync reset
tim_en  out  1  timer enable
idle  out  1  encoder idle (J) drive
eop  out  1  encoder SE0 drive
eop_new_bit  out  1  bit strobe to the encoder during EOP
fifo_read  out  1  one-cycle FIFO pop
busy  out  1  packet in progress
done  out  1  one-cycle completion pulse
tx_err  out  1  sticky underrun flag; cleared on the next accepted start

Behaviour:
- Reset values: all outputs 0 except idle=1, select=1, fsm_byte=SYNC_BYTE. Reset mid-packet returns to IDLE immediately, with no EOP.
- States: IDLE, ARM, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
- IDLE: on start, latch pid, min(data_len,MAX_LEN) into a remaining-byte counter, and crc_en. Clear tx_err. Go to ARM.
- ARM (1 cycle): select=1, fsm_byte=SYNC_BYTE, load_en=1, tim_rst=1, busy=1. Next cycle: tim_en=1, idle=0, state SYNC.
- In each byte state, the select/fsm_byte for the NEXT byte are valid before load_byte. The transition happens on the load_byte cycle.
  - SYNC: stage PID (select=1, fsm_byte={~pid,pid}); load_byte -> PID.
  - PID: stage next = DATA if remaining>0, else CRC_LO if crc_en, else end.
  - DATA: select=0. fifo_read=1 on each load_byte that loads a FIFO byte. Decrement remaining; at 0, stage CRC_LO or end.
  - CRC_LO: select=2; load_byte -> CRC_HI with select=3. CRC_HI: load_byte -> end.
- End (load_byte in the final byte state): tim_en=0, eop=1, internal counter cleared, state EOP_SE0.
- EOP_SE0: eop_new_bit pulses once every BIT_CLKS clocks, first pulse BIT_CLKS cycles after entry. After 2 pulses: eop=0 and EOP_J, with J driven by the encoder.
- EOP_J: after 1 further pulse: idle=1, busy=0, done=1 for one cycle, then IDLE.
- Simultaneous start and done cycle: start is ignored.
- load_byte in IDLE/ARM/EOP states is ignored.
- Zero-length with crc_en=0 (handshake packet): SYNC, PID, EOP.

Optional Feature:
Macro UNDERRUN_CHECK_EN.
- Defined: if fifo_empty=1 on a load_byte that loads a FIFO byte, suppress fifo_read, set tx_err=1, skip the remaining data and CRC, and go directly to EOP_SE0. The abort uses the same EOP timing as a normal end.
- Undefined: fifo_empty is unused and tx_err is tied 0. The FIFO is guaranteed valid by the protocol FSM.

Test Plan:
- pid=4'h2, data_len=0, crc_en=0 -> bytes 0x80, 0xD2; eop=1 for exactly 16 clks, then 8 clks J; done once; fifo_read never asserted.
- pid=4'h3, data_len=3, crc_en=1 -> select sequence 1,1,0,0,0,2,3; exactly 3 fifo_read pulses, each on a load_byte; then EOP, done, busy=0.
- data_len=64 then data_len=100 -> 64 fifo_read pulses in both cases.
- start pulsed while busy -> ignored; packet byte order and count unchanged; no second done.
- rst asserted during DATA -> same cycle: idle=1, tim_en=0, eop=0, busy=0; a fresh start afterwards sends a complete packet.
- UNDERRUN_CHECK_EN, data_len=4, fifo_empty=1 at the 3rd data load -> tx_err=1, only 2 fifo_read pulses, no CRC select, EOP of 16 clks, done=1.
